// File: rtl/mips_mon_pkg.sv
// Shared types and defaults for the on-chip store monitor.
package mips_mon_pkg;

   typedef enum logic [1:0] {
      StRun  = 2'd0,
      StPass = 2'd1,
      StFail = 2'd2
   } mon_state_e;

   localparam logic [31:0] DefPassAddr  = 32'd84;
   localparam logic [31:0] DefPassData  = 32'd7;
   localparam logic [31:0] DefAllowAddr = 32'd80;

   // Each logged store is {address, data}.
   localparam int unsigned EntryW = 64;

endpackage

// File: rtl/store_fifo.sv
// First-word fall-through FIFO for logged stores, with a sticky overflow flag.
module store_fifo
   import mips_mon_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = EntryW
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_entry_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             overflow_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]    count_q;
   logic             overflow_q;
   logic             do_push, do_pop;

   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == (PtrW + 1)'(DEPTH));
   assign overflow_o = overflow_q;
   assign head_o     = empty_o ? '0 : mem_q[rd_ptr_q];

   // A push into a full FIFO still fits when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_entry_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (!do_push && do_pop) begin
            count_q <= count_q - 1'b1;
         end
         if (push_i && !do_push) begin
            overflow_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/store_monitor.sv
// Watches the MIPS data-memory write bus, decides pass/fail, counts and logs stores.
module store_monitor
   import mips_mon_pkg::*;
#(
   parameter logic [31:0] PASS_ADDR  = DefPassAddr,
   parameter logic [31:0] PASS_DATA  = DefPassData,
   parameter logic [31:0] ALLOW_ADDR = DefAllowAddr,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             memwrite,
   input  logic [31:0]      dataadr,
   input  logic [31:0]      writedata,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic [31:0]      fail_addr,
   output logic [31:0]      fail_data,
   output logic [CNT_W-1:0] store_count,
   input  logic             rd_en,
   output logic             rd_valid,
   output logic [31:0]      rd_addr,
   output logic [31:0]      rd_data,
   output logic             empty,
   output logic             full,
   output logic             overflow
);

   mon_state_e        state_q, state_d;
   logic [31:0]       fail_addr_q, fail_data_q;
   logic [CNT_W-1:0]  count_q;
   logic              accept;
   logic [EntryW-1:0] head;

   // Only stores seen while still running are counted and logged.
   assign accept = memwrite && (state_q == StRun);

   always_comb begin
      state_d = state_q;
      if (accept) begin
         if (dataadr == PASS_ADDR && writedata == PASS_DATA) begin
            state_d = StPass;
         end else if (dataadr != ALLOW_ADDR) begin
            state_d = StFail;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StRun;
         fail_addr_q <= '0;
         fail_data_q <= '0;
         count_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept && state_d == StFail) begin
            fail_addr_q <= dataadr;
            fail_data_q <= writedata;
         end
         if (accept && count_q != '1) begin
            count_q <= count_q + 1'b1;
         end
      end
   end

   assign done        = (state_q != StRun);
   assign pass        = (state_q == StPass);
   assign fail        = (state_q == StFail);
   assign fail_addr   = fail_addr_q;
   assign fail_data   = fail_data_q;
   assign store_count = count_q;

   store_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EntryW)
   ) u_fifo (
      .clk_i        (clk),
      .reset_i      (reset),
      .push_i       (accept),
      .push_entry_i ({dataadr, writedata}),
      .pop_i        (rd_en),
      .head_o       (head),
      .empty_o      (empty),
      .full_o       (full),
      .overflow_o   (overflow)
   );

   assign rd_valid = !empty;
   assign rd_addr  = head[63:32];
   assign rd_data  = head[31:0];

endmodule

// File: tb/tb_store_monitor.sv
// Self-checking bench for store_monitor: vector table plus FIFO scoreboard.
module tb_store_monitor;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memwrite = 1'b0;
   logic [31:0] dataadr = '0;
   logic [31:0] writedata = '0;
   logic        rd_en = 1'b0;
   logic        done, pass, fail, rd_valid, empty, full, overflow;
   logic [31:0] fail_addr, fail_data, rd_addr, rd_data;
   logic [15:0] store_count;

   int n_chk = 0;
   int n_fail = 0;

   // Scoreboard of expected FIFO contents {addr, data} plus a tiny reference model.
   logic [63:0] sb[$];
   bit          m_run = 1'b1;
   bit          m_ovf = 1'b0;

   typedef struct {
      bit          rst;
      logic [31:0] addr;
      logic [31:0] data;
      bit          exp_pass;
      bit          exp_fail;
      logic [15:0] exp_cnt;
      logic [31:0] exp_faddr;
      logic [31:0] exp_fdata;
   } vec_t;

   vec_t vecs[7];

   store_monitor dut (
      .clk         (clk),
      .reset       (reset),
      .memwrite    (memwrite),
      .dataadr     (dataadr),
      .writedata   (writedata),
      .done        (done),
      .pass        (pass),
      .fail        (fail),
      .fail_addr   (fail_addr),
      .fail_data   (fail_data),
      .store_count (store_count),
      .rd_en       (rd_en),
      .rd_valid    (rd_valid),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .empty       (empty),
      .full        (full),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void model_store(input logic [31:0] a, input logic [31:0] d);
      if (m_run) begin
         if (sb.size() < 8) sb.push_back({a, d});
         else m_ovf = 1'b1;
         if ((a == 32'd84 && d == 32'd7) || a != 32'd80) m_run = 1'b0;
      end
   endfunction

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      memwrite = 1'b1;
      dataadr = a;
      writedata = d;
      model_store(a, d);
      tick();
      memwrite = 1'b0;
   endtask

   task automatic pop_chk();
      logic [63:0] e;
      if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL pop: scoreboard empty, rd_valid=%0b", rd_valid);
         return;
      end
      e = sb.pop_front();
      chk("pop rd_valid", {31'd0, rd_valid}, 32'd1);
      chk("pop rd_addr", rd_addr, e[63:32]);
      chk("pop rd_data", rd_data, e[31:0]);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic drain();
      while (sb.size() > 0) pop_chk();
      chk("drain empty", {31'd0, empty}, 32'd1);
      chk("drain rd_addr", rd_addr, 32'd0);
      chk("drain rd_data", rd_data, 32'd0);
   endtask

   task automatic chk_reset();
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst pass", {31'd0, pass}, 32'd0);
      chk("rst fail", {31'd0, fail}, 32'd0);
      chk("rst overflow", {31'd0, overflow}, 32'd0);
      chk("rst fail_addr", fail_addr, 32'd0);
      chk("rst fail_data", fail_data, 32'd0);
      chk("rst count", {16'd0, store_count}, 32'd0);
      chk("rst empty", {31'd0, empty}, 32'd1);
      chk("rst full", {31'd0, full}, 32'd0);
      chk("rst rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst rd_addr", rd_addr, 32'd0);
      chk("rst rd_data", rd_data, 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
      m_run = 1'b1;
      m_ovf = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'd80, 32'd1, 1'b0, 1'b0, 16'd1, 32'd0, 32'd0};
      vecs[1] = '{1'b0, 32'd80, 32'd2, 1'b0, 1'b0, 16'd2, 32'd0, 32'd0};
      vecs[2] = '{1'b0, 32'd84, 32'd7, 1'b1, 1'b0, 16'd3, 32'd0, 32'd0};
      vecs[3] = '{1'b1, 32'd80, 32'd5, 1'b0, 1'b0, 16'd1, 32'd0, 32'd0};
      vecs[4] = '{1'b0, 32'd60, 32'd9, 1'b0, 1'b1, 16'd2, 32'd60, 32'd9};
      vecs[5] = '{1'b0, 32'd84, 32'd7, 1'b0, 1'b1, 16'd2, 32'd60, 32'd9};
      vecs[6] = '{1'b1, 32'd84, 32'd6, 1'b0, 1'b1, 16'd1, 32'd84, 32'd6};

      tick();
      reset = 1'b0;
      chk_reset();

      // Pass / fail classification; each reset row first drains what was logged.
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].rst) begin
            drain();
            do_reset();
         end
         store(vecs[i].addr, vecs[i].data);
         chk($sformatf("v%0d pass", i), {31'd0, pass}, {31'd0, vecs[i].exp_pass});
         chk($sformatf("v%0d fail", i), {31'd0, fail}, {31'd0, vecs[i].exp_fail});
         chk($sformatf("v%0d done", i), {31'd0, done},
             {31'd0, vecs[i].exp_pass | vecs[i].exp_fail});
         chk($sformatf("v%0d count", i), {16'd0, store_count}, {16'd0, vecs[i].exp_cnt});
         chk($sformatf("v%0d fail_addr", i), fail_addr, vecs[i].exp_faddr);
         chk($sformatf("v%0d fail_data", i), fail_data, vecs[i].exp_fdata);
      end
      drain();

      // Overflow: ten stores into an 8-deep FIFO with no reads.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         store(32'd80, i);
         if (i == 6) chk("ovf full after 7", {31'd0, full}, 32'd0);
         if (i == 7) begin
            chk("ovf full after 8", {31'd0, full}, 32'd1);
            chk("ovf overflow after 8", {31'd0, overflow}, 32'd0);
         end
         if (i == 8) chk("ovf overflow after 9", {31'd0, overflow}, {31'd0, m_ovf});
      end
      chk("ovf count", {16'd0, store_count}, 32'd10);
      drain();
      chk("ovf sticky", {31'd0, overflow}, 32'd1);

      // Push and pop together on a full FIFO.
      do_reset();
      for (int i = 0; i < 8; i++) store(32'd80, 32'd100 + i);
      chk("sim full before", {31'd0, full}, 32'd1);
      chk("sim head before", rd_data, 32'd100);
      void'(sb.pop_front());
      memwrite = 1'b1;
      dataadr = 32'd80;
      writedata = 32'd200;
      rd_en = 1'b1;
      model_store(32'd80, 32'd200);
      tick();
      memwrite = 1'b0;
      rd_en = 1'b0;
      chk("sim full after", {31'd0, full}, 32'd1);
      chk("sim overflow", {31'd0, overflow}, 32'd0);
      chk("sim head after", rd_data, 32'd101);
      chk("sim count", {16'd0, store_count}, 32'd9);
      drain();

      // Pop request on an empty FIFO must leave pointers untouched.
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("empty pop empty", {31'd0, empty}, 32'd1);
      chk("empty pop rd_valid", {31'd0, rd_valid}, 32'd0);
      store(32'd80, 32'd55);
      chk("empty pop full", {31'd0, full}, 32'd0);
      drain();

      // Reset mid-run after PASS, with stores and pops driven during reset.
      do_reset();
      store(32'd80, 32'd1);
      store(32'd80, 32'd2);
      store(32'd84, 32'd7);
      chk("mid pass", {31'd0, pass}, 32'd1);
      reset = 1'b1;
      memwrite = 1'b1;
      dataadr = 32'd60;
      writedata = 32'd9;
      rd_en = 1'b1;
      tick();
      reset = 1'b0;
      memwrite = 1'b0;
      rd_en = 1'b0;
      sb.delete();
      m_run = 1'b1;
      m_ovf = 1'b0;
      chk_reset();
      store(32'd80, 32'd1);
      chk("mid count", {16'd0, store_count}, 32'd1);
      chk("mid done", {31'd0, done}, 32'd0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
